btn_uart_scheduler: RTL and testbench

Sequences debounced push-button events onto the shared UART transmitter. Takes N_BTN debounced button levels, each from one Debounce instance, and detects press (rising) edges. Pending events are latched per button, round-robin arbitrated, and issued one byte at a time to the UART TX through a start/busy handshake. Sits between the debounce bank and the UART TX in the Connect top level.

---
 rtl/btn_uart_scheduler_if.sv | 8 +
 rtl/btn_uart_scheduler.sv | 79 +++++++
 tb/tb_btn_uart_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/btn_uart_scheduler_if.sv
// btn_uart_scheduler_if: byte/start/busy handshake between the button scheduler and the UART transmitter
interface btn_uart_scheduler_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/btn_uart_scheduler.sv
// btn_uart_scheduler: latches button press events and issues them round-robin as single bytes to the UART TX
module btn_uart_scheduler #(
  parameter int         N_BTN     = 4,
  parameter logic [7:0] CODE_BASE = 8'h30,
  parameter int         BUSY_TO   = 8
) (
  input  logic                 src_clk,
  input  logic                 rst,
  input  logic [N_BTN-1:0]     pb_in,
  btn_uart_scheduler_if.master tx,
  output logic [N_BTN-1:0]     pending,
  output logic                 overflow
);
  localparam int GW = N_BTN > 1 ? $clog2(N_BTN) : 1;
  localparam int CW = $clog2(BUSY_TO);
  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;
  state_t           state_q;
  logic [N_BTN-1:0] pb_prev_q, pend_q, pend_d, press, clr;
  logic             ovf_q, ovf_d;
  logic [GW-1:0]    last_q, g_q, grant;
  logic [CW-1:0]    cnt_q;
  logic             start_q;
  logic [7:0]       data_q;
  assign press    = pb_in & ~pb_prev_q;
  assign clr      = (state_q == START) ? (N_BTN'(1) << g_q) : '0;
  assign pend_d   = press | (pend_q & ~clr);
  assign ovf_d    = ovf_q | |(press & pend_q & ~clr);
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign tx.tx_start = start_q;
  assign tx.tx_data  = data_q;
  // round-robin pick: scanning downward lets the nearest index after last_q overwrite the others
  always_comb begin
    logic [GW-1:0] idx;
    grant = last_q;
    idx   = '0;
    for (int i = N_BTN; i >= 1; i--) begin
      idx = GW'((int'(last_q) + i) % N_BTN);
      if (pend_q[idx]) grant = idx;
    end
  end
  // edge history and per-button event latches; a press coinciding with its own grant survives the clear
  always_ff @(posedge src_clk) begin
    pb_prev_q <= pb_in;
    pend_q    <= rst ? '0 : pend_d;
    ovf_q     <= rst ? 1'b0 : ovf_d;
  end
  // transmit sequencer with registered start pulse and held byte
  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GW'(N_BTN - 1);
      g_q     <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (|pend_q) begin
          g_q     <= grant;
          last_q  <= grant;
          data_q  <= CODE_BASE + 8'(grant);
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT_HI;
        end
        WAIT_HI: if (tx.tx_busy) state_q <= WAIT_LO;
          else if (cnt_q == CW'(BUSY_TO - 1)) state_q <= IDLE;
          else cnt_q <= cnt_q + CW'(1);
        WAIT_LO: if (!tx.tx_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_btn_uart_scheduler.sv
// tb_btn_uart_scheduler: vector table plus directed sequences with a simple UART busy model
module tb_btn_uart_scheduler;
  typedef struct packed {
    logic       r;
    logic [3:0] pb;
    logic       b;
    logic       st;
    logic [7:0] d;
    logic [3:0] p;
    logic       o;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1, busy_r = 1'b0, model_en = 1'b0;
  logic [3:0] pb = 4'b0000, pending;
  logic       overflow;
  int         bcnt = 0, n_cmp = 0, n_err = 0;
  vec_t       tv [24];
  btn_uart_scheduler_if tx();
  btn_uart_scheduler #(.N_BTN(4), .CODE_BASE(8'h30), .BUSY_TO(8)) dut (
    .src_clk(clk), .rst(rst), .pb_in(pb), .tx(tx), .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  // UART stand-in: busy rises the cycle after tx_start and stays high for 10 cycles
  always @(posedge clk) begin
    if (model_en && tx.tx_start) bcnt <= 10;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx.tx_busy = model_en ? (bcnt != 0) : busy_r;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic reset_seq(input logic en);
    rst = 1'b1;
    pb = 4'b0000;
    busy_r = 1'b0;
    model_en = en;
    repeat (12) cyc();
    rst = 1'b0;
    cyc();
  endtask
  task automatic wait_start(input string nm, input logic [7:0] exp_d, input int exp_n);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!tx.tx_start && n < 200);
    chk({nm, " latency"}, n, exp_n);
    chk({nm, " data"}, tx.tx_data, exp_d);
    chk({nm, " busy_at_start"}, tx.tx_busy, 0);
  endtask
  task automatic quiet(input string nm, input int n);
    int c = 0;
    repeat (n) begin
      cyc();
      c += int'(tx.tx_start);
    end
    chk(nm, c, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tv[1]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tv[2]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tv[3]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tv[4]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tv[5]  = '{1'b0, 4'b0110, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b0};
    tv[6]  = '{1'b0, 4'b0110, 1'b0, 1'b1, 8'h32, 4'b0100, 1'b0};
    tv[7]  = '{1'b0, 4'b0110, 1'b0, 1'b0, 8'h32, 4'b0000, 1'b0};
    tv[8]  = '{1'b0, 4'b0110, 1'b1, 1'b0, 8'h32, 4'b0000, 1'b0};
    tv[9]  = '{1'b0, 4'b0110, 1'b1, 1'b0, 8'h32, 4'b0000, 1'b0};
    tv[10] = '{1'b0, 4'b0110, 1'b0, 1'b0, 8'h32, 4'b0000, 1'b0};
    tv[11] = '{1'b0, 4'b1010, 1'b0, 1'b0, 8'h32, 4'b1000, 1'b0};
    tv[12] = '{1'b0, 4'b1010, 1'b0, 1'b1, 8'h33, 4'b1000, 1'b0};
    tv[13] = '{1'b0, 4'b1010, 1'b0, 1'b0, 8'h33, 4'b0000, 1'b0};
    tv[14] = '{1'b0, 4'b1010, 1'b1, 1'b0, 8'h33, 4'b0000, 1'b0};
    tv[15] = '{1'b0, 4'b1010, 1'b0, 1'b0, 8'h33, 4'b0000, 1'b0};
    tv[16] = '{1'b0, 4'b1011, 1'b0, 1'b0, 8'h33, 4'b0001, 1'b0};
    tv[17] = '{1'b0, 4'b1010, 1'b0, 1'b1, 8'h30, 4'b0001, 1'b0};
    tv[18] = '{1'b0, 4'b1011, 1'b0, 1'b0, 8'h30, 4'b0001, 1'b0};
    tv[19] = '{1'b0, 4'b1011, 1'b0, 1'b0, 8'h30, 4'b0001, 1'b0};
    tv[20] = '{1'b0, 4'b1011, 1'b1, 1'b0, 8'h30, 4'b0001, 1'b0};
    tv[21] = '{1'b0, 4'b1011, 1'b0, 1'b0, 8'h30, 4'b0001, 1'b0};
    tv[22] = '{1'b0, 4'b1011, 1'b0, 1'b1, 8'h30, 4'b0001, 1'b0};
    tv[23] = '{1'b0, 4'b1011, 1'b0, 1'b0, 8'h30, 4'b0000, 1'b0};
    foreach (tv[i]) begin
      rst = tv[i].r;
      pb = tv[i].pb;
      busy_r = tv[i].b;
      cyc();
      chk($sformatf("v%0d tx_start", i), tx.tx_start, tv[i].st);
      chk($sformatf("v%0d tx_data", i), tx.tx_data, tv[i].d);
      chk($sformatf("v%0d pending", i), pending, tv[i].p);
      chk($sformatf("v%0d overflow", i), overflow, tv[i].o);
    end
    reset_seq(1'b1);
    pb = 4'b1011;
    wait_start("simul b0", 8'h30, 2);
    chk("simul pending", pending, 4'b1011);
    wait_start("simul b1", 8'h31, 13);
    wait_start("simul b3", 8'h33, 13);
    reset_seq(1'b1);
    pb = 4'b0010;
    wait_start("rr b1", 8'h31, 2);
    pb = 4'b1011;
    wait_start("rr b3", 8'h33, 13);
    wait_start("rr b0", 8'h30, 13);
    reset_seq(1'b1);
    pb = 4'b0010;
    wait_start("ovf b1", 8'h31, 2);
    pb = 4'b0011;
    cyc();
    pb = 4'b0010;
    cyc();
    pb = 4'b0011;
    cyc();
    chk("ovf flag", overflow, 1);
    chk("ovf pending", pending, 4'b0001);
    wait_start("ovf b0", 8'h30, 10);
    quiet("ovf single send", 30);
    chk("ovf sticky", overflow, 1);
    reset_seq(1'b0);
    pb = 4'b0001;
    wait_start("to b0", 8'h30, 2);
    pb = 4'b0011;
    wait_start("to b1 after timeout", 8'h31, 10);
    quiet("to no retry", 20);
    chk("to pending", pending, 4'b0000);
    reset_seq(1'b1);
    pb = 4'b0100;
    wait_start("rst b2", 8'h32, 2);
    pb = 4'b0101;
    cyc();
    pb = 4'b0100;
    cyc();
    pb = 4'b0101;
    cyc();
    chk("rst pre ovf", overflow, 1);
    chk("rst pre pending", pending, 4'b0001);
    rst = 1'b1;
    pb = 4'b0000;
    cyc();
    chk("rst tx_start", tx.tx_start, 0);
    chk("rst tx_data", tx.tx_data, 8'h00);
    chk("rst pending", pending, 4'b0000);
    chk("rst overflow", overflow, 0);
    rst = 1'b0;
    quiet("rst no send", 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
